ofdm_cp_insert: RTL and testbench



---
 rtl/ofdm_cp_insert.sv | 91 +++++++++
 tb/tb_ofdm_cp_insert.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_cp_insert.sv
// Cyclic-prefix inserter: buffers one NFFT-sample symbol per bank and replays
// its last NCP samples ahead of the full symbol, ping-ponging between two banks.
module ofdm_cp_insert #(
  parameter int NFFT = 256,
  parameter int NCP  = 64,
  parameter int DW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2*DW-1:0] din,
  input  logic            din_valid,
  output logic            din_ready,
  output logic [2*DW-1:0] dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            sym_start,
  output logic            sym_end
);

  localparam int AW = $clog2(NFFT);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(NFFT - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NFFT + NCP - 1);
  localparam logic [AW-1:0] NCP_MOD  = AW'(NCP % NFFT);

  logic [2*DW-1:0] mem [2][NFFT];

  logic            rst_q;
  logic            wr_bank;
  logic            rd_bank;
  logic [1:0]      full;
  logic [1:0]      full_next;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   rd_cnt;
  logic [AW-1:0]   rd_addr;
  logic            wr_fire;
  logic            wr_done;
  logic            rd_fire;
  logic            rd_done;

  assign din_ready  = !rst_q && !full[wr_bank];
  assign wr_fire    = din_valid && din_ready;
  assign wr_done    = wr_fire && (wr_ptr == LAST_PTR);

  assign dout_valid = full[rd_bank];
  assign rd_fire    = dout_valid && dout_ready;
  assign rd_done    = rd_fire && (rd_cnt == LAST_CNT);

  // Both the prefix address (NFFT-NCP+cnt) and the body address (cnt-NCP)
  // reduce to cnt-NCP modulo NFFT, since NFFT is a power of two.
  assign rd_addr    = rd_cnt[AW-1:0] - NCP_MOD;
  assign dout       = mem[rd_bank][rd_addr];
  assign sym_start  = dout_valid && (rd_cnt == '0);
  assign sym_end    = dout_valid && (rd_cnt == LAST_CNT);

  // NOTE: combinational logic uses blocking '=' with a default first so no
  // latch is inferred; clocked state below uses non-blocking '<=' only.
  always_comb begin
    full_next = full;
    if (wr_done) full_next[wr_bank] = 1'b1;
    if (rd_done) full_next[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
      wr_ptr  <= '0;
      rd_cnt  <= '0;
    end else begin
      full <= full_next;
      if (wr_fire) begin
        wr_ptr <= wr_done ? '0 : wr_ptr + AW'(1);
        if (wr_done) wr_bank <= ~wr_bank;
      end
      if (rd_fire) begin
        rd_cnt <= rd_done ? '0 : rd_cnt + CW'(1);
        if (rd_done) rd_bank <= ~rd_bank;
      end
    end
  end

  // NOTE: the sample buffer is deliberately not reset; the full flags gate
  // every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank][wr_ptr] <= din;
  end

endmodule

// File: tb/tb_ofdm_cp_insert.sv
// Directed bench for ofdm_cp_insert: NFFT=8/NCP=2 main instance plus an
// NCP=NFFT instance, checking sequences, framing flags, handshake and reset.
module tb_ofdm_cp_insert;

  localparam int NFFT = 8;
  localparam int NCP  = 2;
  localparam int DW   = 16;
  localparam int SYM  = NFFT + NCP;

  typedef struct {
    logic [2*DW-1:0] d;
    logic            ss;
    logic            se;
    int              cyc;
  } out_t;

  logic            clk;
  logic            rst;
  logic [2*DW-1:0] din;
  logic            din_valid;
  logic            din_ready;
  logic [2*DW-1:0] dout;
  logic            dout_valid;
  logic            dout_ready;
  logic            sym_start;
  logic            sym_end;

  logic            rst2;
  logic [2*DW-1:0] din2;
  logic            din_valid2;
  logic            din_ready2;
  logic [2*DW-1:0] dout2;
  logic            dout_valid2;
  logic            dout_ready2;
  logic            sym_start2;
  logic            sym_end2;

  int              n_checks;
  int              n_pass;
  int              cyc;
  int              stall_cnt;
  logic            last_din_ready;
  logic            hold_pending;
  logic [34:0]     held_val;
  logic [7:0]      lfsr;
  out_t            out_q[$];
  out_t            out_q2[$];

  ofdm_cp_insert #(.NFFT(NFFT), .NCP(NCP), .DW(DW)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .sym_start  (sym_start),
    .sym_end    (sym_end)
  );

  ofdm_cp_insert #(.NFFT(NFFT), .NCP(NFFT), .DW(DW)) u_dut_full (
    .clk        (clk),
    .rst        (rst2),
    .din        (din2),
    .din_valid  (din_valid2),
    .din_ready  (din_ready2),
    .dout       (dout2),
    .dout_valid (dout_valid2),
    .dout_ready (dout_ready2),
    .sym_start  (sym_start2),
    .sym_end    (sym_end2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [2*DW-1:0] sample(input int k);
    logic [DW-1:0] i_part;
    logic [DW-1:0] q_part;
    i_part = DW'(k);
    q_part = DW'(-k);
    return {i_part, q_part};
  endfunction

  // One clock: drive inputs at the negedge, observe #1 later, record the
  // transfers that the coming posedge will complete, return at next negedge.
  task automatic step(input logic iv, input logic [2*DW-1:0] id, input int mode,
                      output logic acc);
    out_t e;
    din_valid = iv;
    din       = id;
    case (mode)
      0:       dout_ready = 1'b0;
      1:       dout_ready = 1'b1;
      default: begin
        dout_ready = lfsr[0];
        lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
    endcase
    #1;
    if (hold_pending)
      check("hold_stable", {29'd0, dout_valid, sym_start, sym_end, dout}, {29'd0, held_val});
    hold_pending   = dout_valid && !dout_ready;
    held_val       = {dout_valid, sym_start, sym_end, dout};
    last_din_ready = din_ready;
    acc            = iv && din_ready;
    if (iv && !din_ready) stall_cnt++;
    if (dout_valid && dout_ready) begin
      e.d   = dout;
      e.ss  = sym_start;
      e.se  = sym_end;
      e.cyc = cyc;
      out_q.push_back(e);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic feed(input int base, input int n, input int mode);
    int   k;
    int   budget;
    logic acc;
    k      = 0;
    budget = 400;
    while (k < n && budget > 0) begin
      step(1'b1, sample(base + k), mode, acc);
      if (acc) k++;
      budget--;
    end
    din_valid = 1'b0;
    if (k < n) check("feed_timeout", k, n);
  endtask

  task automatic drain(input int n, input int mode);
    int   budget;
    logic acc;
    budget = 400;
    while (out_q.size() < n && budget > 0) begin
      step(1'b0, '0, mode, acc);
      budget--;
    end
    dout_ready = 1'b0;
    if (out_q.size() < n) check("drain_timeout", out_q.size(), n);
  endtask

  // Expected ordering for NFFT=8, NCP=2: last two samples, then all eight.
  task automatic expect_symbol(input string tag, input int base);
    int   idx [SYM] = '{6, 7, 0, 1, 2, 3, 4, 5, 6, 7};
    out_t e;
    check({tag, "_count"}, out_q.size() >= SYM, 1);
    if (out_q.size() < SYM) return;
    for (int j = 0; j < SYM; j++) begin
      e = out_q.pop_front();
      check($sformatf("%s_data[%0d]", tag, j), e.d, sample(base + idx[j]));
      check($sformatf("%s_flags[%0d]", tag, j), {e.ss, e.se}, {j == 0, j == SYM - 1});
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    @(negedge clk);
    rst          = 1'b0;
    hold_pending = 1'b0;
    out_q.delete();
  endtask

  initial begin
    int   first_cyc;
    int   last_cyc;
    int   k2;
    int   budget2;
    out_t e2;

    n_checks     = 0;
    n_pass       = 0;
    cyc          = 0;
    stall_cnt    = 0;
    hold_pending = 1'b0;
    held_val     = '0;
    lfsr         = 8'hA5;
    din          = '0;
    din_valid    = 1'b0;
    dout_ready   = 1'b0;
    rst2         = 1'b1;
    din2         = '0;
    din_valid2   = 1'b0;
    dout_ready2  = 1'b0;

    // Reset state: everything low in the cycle after reset, din_ready rises one later.
    do_reset();
    check("rst_din_ready", din_ready, 0);
    check("rst_valid_flags", {dout_valid, sym_start, sym_end}, 3'b000);
    @(negedge clk);
    check("rst_din_ready_rise", din_ready, 1);

    // Single symbol ramp; first valid exactly one cycle after the 8th input.
    feed(0, NFFT, 1);
    check("t1_no_early_out", out_q.size(), 0);
    check("t1_valid_after_8th", dout_valid, 1);
    check("t1_sym_start_now", sym_start, 1);
    drain(SYM, 1);
    expect_symbol("t1", 0);

    // Three back-to-back symbols with no output gaps and input throttling.
    stall_cnt = 0;
    feed(0, 3 * NFFT, 1);
    drain(3 * SYM, 1);
    if (out_q.size() >= 3 * SYM) begin
      first_cyc = out_q[0].cyc;
      last_cyc  = out_q[3 * SYM - 1].cyc;
      check("t2_no_gaps", last_cyc - first_cyc, 3 * SYM - 1);
    end
    check("t2_din_throttled", stall_cnt > 0, 1);
    expect_symbol("t2_s0", 0);
    expect_symbol("t2_s1", 8);
    expect_symbol("t2_s2", 16);

    // Random output backpressure: same sequence, held outputs stable.
    feed(0, NFFT, 2);
    drain(SYM, 2);
    expect_symbol("t3", 0);

    // Fill both banks with output blocked, then release one bank.
    feed(0, 2 * NFFT, 0);
    check("t4_both_full_ready", din_ready, 0);
    drain(SYM, 1);
    check("t4_ready_at_release", last_din_ready, 0);
    check("t4_ready_after_release", din_ready, 1);
    drain(2 * SYM, 1);
    expect_symbol("t4_s0", 0);
    expect_symbol("t4_s1", 8);

    // Reset in the middle of emitting a symbol.
    feed(0, NFFT, 0);
    drain(4, 1);
    check("t6_pre_reset_first", out_q[0].d, sample(6));
    do_reset();
    check("t6_valid_flags", {dout_valid, sym_start, sym_end}, 3'b000);
    check("t6_din_ready_low", din_ready, 0);
    @(negedge clk);
    check("t6_din_ready_high", din_ready, 1);
    check("t6_still_no_out", dout_valid, 0);
    feed(100, NFFT, 1);
    drain(SYM, 1);
    expect_symbol("t6", 100);

    // NCP == NFFT: prefix is the whole symbol.
    rst2 = 1'b0;
    check("t5_rst_din_ready", din_ready2, 0);
    k2      = 0;
    budget2 = 100;
    while (out_q2.size() < 2 * NFFT && budget2 > 0) begin
      din2        = sample(k2);
      din_valid2  = (k2 < NFFT);
      dout_ready2 = 1'b1;
      #1;
      if (din_valid2 && din_ready2) k2++;
      if (dout_valid2 && dout_ready2) begin
        e2.d   = dout2;
        e2.ss  = sym_start2;
        e2.se  = sym_end2;
        e2.cyc = 0;
        out_q2.push_back(e2);
      end
      budget2--;
      @(negedge clk);
    end
    din_valid2  = 1'b0;
    dout_ready2 = 1'b0;
    check("t5_count", out_q2.size(), 2 * NFFT);
    for (int j = 0; j < 2 * NFFT && out_q2.size() > 0; j++) begin
      e2 = out_q2.pop_front();
      check($sformatf("t5_data[%0d]", j), e2.d, sample(j % NFFT));
      check($sformatf("t5_flags[%0d]", j), {e2.ss, e2.se}, {j == 0, j == 2 * NFFT - 1});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
